// File: rtl/fetch_unit_l2_pkg.sv
// Shared types and constants for the fetch unit and its response buffer.
package fetch_unit_l2_pkg;

  localparam int P_INST_BYTES = 4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_l2_if.sv
// Memory request/response and fetch-to-decode handshake bundle.
interface fetch_unit_l2_if #(
  parameter int p_opaq_bits    = 8,
  parameter int p_seq_num_bits = 5
);
  logic                      mem_req_val;
  logic                      mem_req_rdy;
  logic [31:0]               mem_req_addr;
  logic [p_opaq_bits-1:0]    mem_req_opaque;

  logic                      mem_resp_val;
  logic                      mem_resp_rdy;
  logic [31:0]               mem_resp_data;
  logic [31:0]               mem_resp_addr;
  logic [p_opaq_bits-1:0]    mem_resp_opaque;

  logic                      F_val;
  logic                      F_rdy;
  logic [31:0]               F_inst;
  logic [31:0]               F_pc;
  logic [p_seq_num_bits-1:0] F_seq_num;

  modport master (
    output mem_req_val, mem_req_addr, mem_req_opaque,
    input  mem_req_rdy,
    input  mem_resp_val, mem_resp_data, mem_resp_addr, mem_resp_opaque,
    output mem_resp_rdy,
    output F_val, F_inst, F_pc, F_seq_num,
    input  F_rdy
  );

  modport slave (
    input  mem_req_val, mem_req_addr, mem_req_opaque,
    output mem_req_rdy,
    output mem_resp_val, mem_resp_data, mem_resp_addr, mem_resp_opaque,
    input  mem_resp_rdy,
    input  F_val, F_inst, F_pc, F_seq_num,
    output F_rdy
  );
endinterface

// File: rtl/fetch_unit_l2_fifo.sv
// Synchronous FIFO with flush, used to buffer fetched instructions ahead of decode.
module fetch_buffer_fifo #(
  parameter int p_depth = 4,
  parameter int p_width = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [p_width-1:0]             push_data,
  input  logic                           pop,
  input  logic                           flush,
  output logic [p_width-1:0]             pop_data,
  output logic [$clog2(p_depth+1)-1:0]   count,
  output logic                           full,
  output logic                           empty
);
  localparam int AW = $clog2(p_depth);
  localparam int CW = $clog2(p_depth + 1);

  logic [p_width-1:0] storage [p_depth];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      storage[wr_ptr] <= push_data;
    end
  end

  // Depth is a power of two, so pointers wrap on natural overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign pop_data = storage[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == CW'(p_depth));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/fetch_unit_l2.sv
// In-order fetch stage: credit-limited sequential requests, epoch-tagged redirect, buffered delivery to decode.
module fetch_unit_l2
  import fetch_unit_l2_pkg::*;
#(
  parameter logic [31:0] p_rst_addr      = 32'h00000200,
  parameter int          p_num_in_flight = 4,
  parameter int          p_opaq_bits     = 8,
  parameter int          p_seq_num_bits  = 5
) (
  input  logic            clk,
  input  logic            rst,
  fetch_unit_l2_if.master bus,
  input  logic            redirect_val,
  input  logic [31:0]     redirect_target
);
  localparam int CW = $clog2(p_num_in_flight + 1);

  logic [31:0]               fetch_pc;
  logic [p_opaq_bits-1:0]    epoch;
  logic [CW-1:0]             cnt;
  logic [p_seq_num_bits-1:0] seq_num;

  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  logic req_xfer;
  logic resp_match;
  logic stale_drop;
  logic f_xfer;

  // cnt covers both requests still in memory and instructions waiting in the FIFO.
  assign bus.mem_req_val    = !rst && !redirect_val && (cnt < CW'(p_num_in_flight));
  assign bus.mem_req_addr   = fetch_pc;
  assign bus.mem_req_opaque = epoch;
  assign bus.mem_resp_rdy   = 1'b1;
  assign req_xfer           = bus.mem_req_val && bus.mem_req_rdy;

  assign resp_match = !rst && bus.mem_resp_val && !redirect_val && (bus.mem_resp_opaque == epoch);
  assign stale_drop = !rst && bus.mem_resp_val && !resp_match;

  assign push_entry = '{inst: bus.mem_resp_data, pc: bus.mem_resp_addr};

  fetch_buffer_fifo #(
    .p_depth (p_num_in_flight),
    .p_width ($bits(fetch_entry_t))
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (resp_match),
    .push_data (push_entry),
    .pop       (f_xfer),
    .flush     (redirect_val),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.F_val     = !rst && !redirect_val && !fifo_empty;
  assign bus.F_inst    = head.inst;
  assign bus.F_pc      = head.pc;
  assign bus.F_seq_num = seq_num;
  assign f_xfer        = bus.F_val && bus.F_rdy;

  // Flushed FIFO entries free their credits at once; requests still in memory
  // keep theirs until the stale response comes back and is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= p_rst_addr;
      epoch    <= '0;
      cnt      <= '0;
      seq_num  <= '0;
    end else if (redirect_val) begin
      fetch_pc <= redirect_target;
      epoch    <= epoch + 1'b1;
      cnt      <= cnt - fifo_count - CW'(stale_drop);
    end else begin
      if (req_xfer) fetch_pc <= fetch_pc + 32'(P_INST_BYTES);
      if (f_xfer)   seq_num  <= seq_num + 1'b1;
      cnt <= cnt + CW'(req_xfer) - CW'(f_xfer) - CW'(stale_drop);
    end
  end

  a_cnt_bounds: assert property (@(posedge clk) disable iff (rst)
    (cnt <= CW'(p_num_in_flight)) && (cnt >= fifo_count));
  a_push_space: assert property (@(posedge clk) disable iff (rst) !(resp_match && fifo_full));

endmodule
